// File: rtl/remap_accel_mul_pkg.sv
// Shared helpers for the remap pipelined multiplier: product width, config legality,
// rounding constant and saturation bounds (bounds are only used with REMAP_MUL_SAT_EN).
package remap_accel_mul_pkg;

   // Bounds and rounding constants are carried at this width; the product must fit in it.
   localparam int MAX_W = 128;

   function automatic int prod_width(int a_w, int b_w);
      return a_w + b_w + 2;
   endfunction

   function automatic bit cfg_ok(int a_w, int b_w, int num_stage, int shift, int out_w);
      return (a_w > 0) && (b_w > 0) && (num_stage >= 2) && (num_stage <= 8) &&
             (shift >= 0) && (shift <= a_w + b_w - 1) &&
             (out_w >= 1) && (out_w <= a_w + b_w - shift) &&
             (prod_width(a_w, b_w) <= MAX_W);
   endfunction

   function automatic logic [MAX_W-1:0] rnd_const(int shift);
      logic [MAX_W-1:0] one;
      one = MAX_W'(1);
      return (shift > 0) ? (one << (shift - 1)) : '0;
   endfunction

   function automatic logic signed [MAX_W-1:0] sat_max(int out_w, bit out_signed);
      logic signed [MAX_W-1:0] one;
      one = MAX_W'(1);
      return out_signed ? (one <<< (out_w - 1)) - 1 : (one <<< out_w) - 1;
   endfunction

   function automatic logic signed [MAX_W-1:0] sat_min(int out_w, bit out_signed);
      logic signed [MAX_W-1:0] one;
      one = MAX_W'(1);
      return out_signed ? -(one <<< (out_w - 1)) : '0;
   endfunction

endpackage

// File: rtl/remap_accel_mul_pipe_if.sv
// Stream handshake bundle for remap_accel_mul_pipe: operand input side, result output side, busy.
interface remap_accel_mul_pipe_if #(
   parameter int A_W   = 16,
   parameter int B_W   = 16,
   parameter int OUT_W = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [A_W-1:0]   din0;
   logic [B_W-1:0]   din1;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] dout;
   logic             busy;

   modport master (
      output in_valid, din0, din1, out_ready,
      input  in_ready, out_valid, dout, busy
   );

   modport slave (
      input  in_valid, din0, din1, out_ready,
      output in_ready, out_valid, dout, busy
   );
endinterface

// File: rtl/remap_accel_mul_pipe_core.sv
// Bare registered multiply: operand registers, then an optional product register.
// Operands are widened by one bit so a single signed multiplier covers every signedness mix.
module remap_accel_mul_core
   import remap_accel_mul_pkg::*;
#(
   parameter int A_W      = 16,
   parameter int B_W      = 16,
   parameter int A_SIGNED = 0,
   parameter int B_SIGNED = 0,
   parameter bit PROD_REG = 1'b1
) (
   input  logic                                  clk,
   input  logic                                  en,
   input  logic [A_W-1:0]                        a,
   input  logic [B_W-1:0]                        b,
   output logic signed [prod_width(A_W,B_W)-1:0] prod
);
   localparam int P_W = prod_width(A_W, B_W);

   logic signed [A_W:0]   a_q;
   logic signed [B_W:0]   b_q;
   logic signed [P_W-1:0] p_c;

   always_ff @(posedge clk) begin
      if (en) begin
         a_q <= (A_SIGNED != 0) ? {a[A_W-1], a} : {1'b0, a};
         b_q <= (B_SIGNED != 0) ? {b[B_W-1], b} : {1'b0, b};
      end
   end

   assign p_c = P_W'(a_q) * P_W'(b_q);

   if (PROD_REG) begin : g_prod_reg
      logic signed [P_W-1:0] p_q;
      always_ff @(posedge clk) begin
         if (en) p_q <= p_c;
      end
      assign prod = p_q;
   end else begin : g_prod_comb
      assign prod = p_c;
   end
endmodule

// File: rtl/remap_accel_mul_pipe.sv
// Pipelined multiplier with valid/ready handshake, round-half-up scaling and OUT_W output.
// Define REMAP_MUL_SAT_EN to saturate the scaled result to the OUT_W range instead of wrapping.
module remap_accel_mul_pipe
   import remap_accel_mul_pkg::*;
#(
   parameter int A_W       = 16,
   parameter int B_W       = 16,
   parameter int A_SIGNED  = 0,
   parameter int B_SIGNED  = 0,
   parameter int NUM_STAGE = 4,
   parameter int SHIFT     = 0,
   parameter int OUT_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   remap_accel_mul_pipe_if.slave bus
);
   localparam int P_W        = prod_width(A_W, B_W);
   localparam bit OUT_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
   localparam bit CFG_OK     = cfg_ok(A_W, B_W, NUM_STAGE, SHIFT, OUT_W);

   logic                  adv;
   logic [NUM_STAGE-1:0]  vld_pipe;
   logic signed [P_W-1:0] prod;
   logic signed [P_W-1:0] pre;
   logic signed [P_W-1:0] scaled;
   logic [OUT_W-1:0]      res;

   // Whole pipe moves or whole pipe holds; bubbles are never squeezed out.
   assign adv           = !bus.out_valid || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_pipe[NUM_STAGE-1];
   assign bus.busy      = |vld_pipe;

   always_ff @(posedge clk) begin
      if (reset) vld_pipe <= '0;
      else if (adv) vld_pipe <= {vld_pipe[NUM_STAGE-2:0], bus.in_valid};
   end

   always_ff @(posedge clk) begin
      assert (CFG_OK);
   end

   remap_accel_mul_core #(
      .A_W      (A_W),
      .B_W      (B_W),
      .A_SIGNED (A_SIGNED),
      .B_SIGNED (B_SIGNED),
      .PROD_REG (NUM_STAGE > 2)
   ) u_core (
      .clk  (clk),
      .en   (adv),
      .a    (bus.din0),
      .b    (bus.din1),
      .prod (prod)
   );

   if (NUM_STAGE <= 3) begin : g_no_dly
      assign pre = prod;
   end else begin : g_dly
      logic signed [P_W-1:0] dly [NUM_STAGE-3];
      always_ff @(posedge clk) begin
         if (adv) begin
            dly[0] <= prod;
            for (int i = 1; i < NUM_STAGE - 3; i++) dly[i] <= dly[i-1];
         end
      end
      assign pre = dly[NUM_STAGE-4];
   end

   // Product has two spare MSBs, so adding the half-LSB constant cannot overflow.
   if (SHIFT > 0) begin : g_rnd
      localparam logic signed [P_W-1:0] RND = P_W'(rnd_const(SHIFT));
      logic signed [P_W-1:0] sum;
      assign sum    = pre + RND;
      assign scaled = sum >>> SHIFT;
   end else begin : g_no_rnd
      assign scaled = pre;
   end

`ifdef REMAP_MUL_SAT_EN
   localparam logic signed [MAX_W-1:0] SAT_MAX = sat_max(OUT_W, OUT_SIGNED);
   localparam logic signed [MAX_W-1:0] SAT_MIN = sat_min(OUT_W, OUT_SIGNED);
   logic signed [MAX_W-1:0] sc_ext;

   assign sc_ext = MAX_W'(scaled);

   always_comb begin
      res = scaled[OUT_W-1:0];
      if (sc_ext > SAT_MAX)      res = SAT_MAX[OUT_W-1:0];
      else if (sc_ext < SAT_MIN) res = SAT_MIN[OUT_W-1:0];
   end
`else
   assign res = OUT_W'(scaled);
`endif

   // dout only updates when a real item lands in the output stage.
   always_ff @(posedge clk) begin
      if (reset) bus.dout <= '0;
      else if (adv && vld_pipe[NUM_STAGE-2]) bus.dout <= res;
   end
endmodule

// File: tb/tb_remap_accel_mul_pipe.sv
// Directed bench for remap_accel_mul_pipe across several configurations sharing clk/reset.
module tb_remap_accel_mul_pipe;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   remap_accel_mul_pipe_if #(.A_W(16), .B_W(16), .OUT_W(32)) if_def ();
   remap_accel_mul_pipe_if #(.A_W(8),  .B_W(8),  .OUT_W(16)) if_sgn ();
   remap_accel_mul_pipe_if #(.A_W(16), .B_W(16), .OUT_W(28)) if_shf ();
   remap_accel_mul_pipe_if #(.A_W(4),  .B_W(4),  .OUT_W(8))  if_w8 ();
   remap_accel_mul_pipe_if #(.A_W(4),  .B_W(4),  .OUT_W(7))  if_w7 ();

   remap_accel_mul_pipe u_def (.clk(clk), .reset(reset), .bus(if_def));
   remap_accel_mul_pipe #(.A_W(8), .B_W(8), .A_SIGNED(1), .B_SIGNED(1), .OUT_W(16))
      u_sgn (.clk(clk), .reset(reset), .bus(if_sgn));
   remap_accel_mul_pipe #(.SHIFT(4), .OUT_W(28))
      u_shf (.clk(clk), .reset(reset), .bus(if_shf));
   remap_accel_mul_pipe #(.A_W(4), .B_W(4), .OUT_W(8))
      u_w8 (.clk(clk), .reset(reset), .bus(if_w8));
   remap_accel_mul_pipe #(.A_W(4), .B_W(4), .OUT_W(7))
      u_w7 (.clk(clk), .reset(reset), .bus(if_w7));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++; if (if_def.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h want 0", if_def.out_valid); end
      checks++; if (if_def.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", if_def.busy); end
      checks++; if (if_def.dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %0h want 0", if_def.dout); end
      checks++; if (if_def.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h want 1", if_def.in_ready); end
      checks++; if (if_w7.dout !== 7'h0) begin errors++; $display("FAIL reset_dout_w7 got %0h want 0", if_w7.dout); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_unsigned_max();
      int lat;
      if_def.din0 = 16'hFFFF; if_def.din1 = 16'hFFFF; if_def.in_valid = 1'b1; if_def.out_ready = 1'b1;
      #1;
      checks++; if (if_def.in_ready !== 1'b1) begin errors++; $display("FAIL umax_in_ready got %0h want 1", if_def.in_ready); end
      tick();
      if_def.in_valid = 1'b0;
      lat = 1;
      while (!if_def.out_valid && lat < 20) begin tick(); lat++; end
      checks++; if (lat !== 4) begin errors++; $display("FAIL umax_latency got %0d want 4", lat); end
      checks++; if (if_def.dout !== 32'hFFFE0001) begin errors++; $display("FAIL umax_dout got %0h want fffe0001", if_def.dout); end
      tick();
      checks++; if (if_def.out_valid !== 1'b0) begin errors++; $display("FAIL umax_single got %0h want 0", if_def.out_valid); end
   endtask

   task automatic test_signed();
      int lat;
      if_sgn.din0 = 8'h80; if_sgn.din1 = 8'h7F; if_sgn.in_valid = 1'b1; if_sgn.out_ready = 1'b1;
      tick();
      if_sgn.in_valid = 1'b0;
      lat = 1;
      while (!if_sgn.out_valid && lat < 20) begin tick(); lat++; end
      checks++; if (lat !== 4) begin errors++; $display("FAIL signed_latency got %0d want 4", lat); end
      checks++; if (if_sgn.dout !== 16'hC080) begin errors++; $display("FAIL signed_dout got %0h want c080", if_sgn.dout); end
      tick();
   endtask

   task automatic test_shift_round();
      logic [15:0] a_v [4] = '{16'd3, 16'd1, 16'd5, 16'd1};
      logic [15:0] b_v [4] = '{16'd3, 16'd8, 16'd5, 16'd7};
      logic [27:0] e_v [4] = '{28'd1, 28'd1, 28'd2, 28'd0};
      int sent = 0;
      int got = 0;
      if_shf.out_ready = 1'b1;
      for (int c = 0; c < 30 && got < 4; c++) begin
         if_shf.in_valid = (sent < 4);
         if_shf.din0 = a_v[sent % 4];
         if_shf.din1 = b_v[sent % 4];
         #1;
         if (if_shf.out_valid) begin
            checks++;
            if (if_shf.dout !== e_v[got]) begin errors++; $display("FAIL round_item%0d got %0d want %0d", got, if_shf.dout, e_v[got]); end
            got++;
         end
         if (if_shf.in_valid && if_shf.in_ready) sent++;
         tick();
      end
      if_shf.in_valid = 1'b0;
      checks++; if (got !== 4) begin errors++; $display("FAIL round_count got %0d want 4", got); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a_v [20];
      logic [15:0] b_v [20];
      logic [31:0] e_v [20];
      int sent = 0;
      int got = 0;
      for (int i = 0; i < 20; i++) begin
         a_v[i] = 16'(i * 4099 + 7);
         b_v[i] = 16'(65535 - i * 321);
         e_v[i] = {16'h0, a_v[i]} * {16'h0, b_v[i]};
      end
      for (int c = 0; c < 100 && got < 20; c++) begin
         if_def.out_ready = !(c >= 6 && c <= 9);
         if_def.in_valid  = (sent < 20);
         if_def.din0 = a_v[sent % 20];
         if_def.din1 = b_v[sent % 20];
         #1;
         if (!if_def.out_ready && if_def.out_valid) begin
            checks++;
            if (if_def.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc%0d got %0h want 0", c, if_def.in_ready); end
            checks++;
            if (if_def.dout !== e_v[got]) begin errors++; $display("FAIL stall_hold cyc%0d got %0h want %0h", c, if_def.dout, e_v[got]); end
         end
         if (if_def.out_valid && if_def.out_ready) begin
            checks++;
            if (if_def.dout !== e_v[got]) begin errors++; $display("FAIL stream_item%0d got %0h want %0h", got, if_def.dout, e_v[got]); end
            got++;
         end
         if (if_def.in_valid && if_def.in_ready) sent++;
         tick();
      end
      if_def.in_valid = 1'b0;
      if_def.out_ready = 1'b1;
      checks++; if (got !== 20) begin errors++; $display("FAIL stream_count got %0d want 20", got); end
      tick();
      checks++; if (if_def.out_valid !== 1'b0) begin errors++; $display("FAIL stream_extra got %0h want 0", if_def.out_valid); end
      checks++; if (if_def.busy !== 1'b0) begin errors++; $display("FAIL stream_busy got %0h want 0", if_def.busy); end
   endtask

   task automatic test_reset_flush();
      int seen = 0;
      if_def.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if_def.din0 = 16'(100 + i);
         if_def.din1 = 16'(200 + i);
         if_def.in_valid = 1'b1;
         tick();
      end
      if_def.in_valid = 1'b0;
      checks++; if (if_def.busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %0h want 1", if_def.busy); end
      reset = 1'b1;
      tick();
      checks++; if (if_def.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0h want 0", if_def.out_valid); end
      checks++; if (if_def.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0h want 0", if_def.busy); end
      checks++; if (if_def.dout !== 32'h0) begin errors++; $display("FAIL flush_dout got %0h want 0", if_def.dout); end
      reset = 1'b0;
      repeat (10) begin
         tick();
         if (if_def.out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL flush_emitted got %0d want 0", seen); end
   endtask

   task automatic test_width_sat();
      int lat;
      logic [6:0] exp7;
`ifdef REMAP_MUL_SAT_EN
      exp7 = 7'd127;
`else
      exp7 = 7'd97;
`endif
      if_w8.din0 = 4'd15; if_w8.din1 = 4'd15; if_w8.in_valid = 1'b1; if_w8.out_ready = 1'b1;
      if_w7.din0 = 4'd15; if_w7.din1 = 4'd15; if_w7.in_valid = 1'b1; if_w7.out_ready = 1'b1;
      tick();
      if_w8.in_valid = 1'b0;
      if_w7.in_valid = 1'b0;
      lat = 1;
      while (!if_w8.out_valid && lat < 20) begin tick(); lat++; end
      checks++; if (if_w7.out_valid !== 1'b1) begin errors++; $display("FAIL w7_valid got %0h want 1", if_w7.out_valid); end
      checks++; if (if_w8.dout !== 8'd225) begin errors++; $display("FAIL w8_dout got %0d want 225", if_w8.dout); end
      checks++; if (if_w7.dout !== exp7) begin errors++; $display("FAIL w7_dout got %0d want %0d", if_w7.dout, exp7); end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      if_def.in_valid = 1'b0; if_def.din0 = '0; if_def.din1 = '0; if_def.out_ready = 1'b1;
      if_sgn.in_valid = 1'b0; if_sgn.din0 = '0; if_sgn.din1 = '0; if_sgn.out_ready = 1'b1;
      if_shf.in_valid = 1'b0; if_shf.din0 = '0; if_shf.din1 = '0; if_shf.out_ready = 1'b1;
      if_w8.in_valid  = 1'b0; if_w8.din0  = '0; if_w8.din1  = '0; if_w8.out_ready  = 1'b1;
      if_w7.in_valid  = 1'b0; if_w7.din0  = '0; if_w7.din1  = '0; if_w7.out_ready  = 1'b1;
      test_reset();
      test_unsigned_max();
      test_signed();
      test_shift_round();
      test_back_to_back();
      test_reset_flush();
      test_width_sat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
